// File: rtl/gpio_pad_bank.sv
// gpio_pad_bank: a bank of bidirectional GPIO pad channels.
// The output side has per-pad direction and value registers. The input side
// passes each pad through a synchroniser and a per-channel debouncer. Edges
// on the debounced inputs set pending bits, and enabled pending bits are
// ORed into a level interrupt. A small register file gives access to all of this.
module gpio_pad_bank #(
  parameter int NUM_CH      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DB_WIDTH    = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              reg_wr_i,
  input  logic [2:0]        reg_addr_i,
  input  logic [31:0]       reg_wdata_i,
  output logic [31:0]       reg_rdata_o,
  output logic [NUM_CH-1:0] pad_c2p_o,
  output logic [NUM_CH-1:0] pad_c2p_en_o,
  input  logic [NUM_CH-1:0] pad_p2c_i,
  output logic              irq_o
);

  localparam logic [2:0] ADDR_DIR     = 3'd0;
  localparam logic [2:0] ADDR_OUT     = 3'd1;
  localparam logic [2:0] ADDR_IN      = 3'd2;
  localparam logic [2:0] ADDR_IRQ_EN  = 3'd3;
  localparam logic [2:0] ADDR_RISE_EN = 3'd4;
  localparam logic [2:0] ADDR_FALL_EN = 3'd5;
  localparam logic [2:0] ADDR_PEND    = 3'd6;
  localparam logic [2:0] ADDR_DB_THR  = 3'd7;

  logic [NUM_CH-1:0]   dir_q;
  logic [NUM_CH-1:0]   out_q;
  logic [NUM_CH-1:0]   irq_en_q;
  logic [NUM_CH-1:0]   rise_en_q;
  logic [NUM_CH-1:0]   fall_en_q;
  logic [NUM_CH-1:0]   pend_q;
  logic [NUM_CH-1:0]   db_q;
  logic [DB_WIDTH-1:0] db_thr_q;

  logic [NUM_CH-1:0]   sync_q [SYNC_STAGES];
  logic [DB_WIDTH-1:0] db_cnt_q [NUM_CH];
  logic [DB_WIDTH-1:0] db_cnt_d [NUM_CH];

  logic [NUM_CH-1:0]   sync;
  logic [NUM_CH-1:0]   flip;
  logic [NUM_CH-1:0]   rise_evt;
  logic [NUM_CH-1:0]   fall_evt;
  logic [NUM_CH-1:0]   pend_clr;
  logic [NUM_CH-1:0]   wdata_ch;
  logic [DB_WIDTH-1:0] thr_m1;
  logic                unused_wdata;

  // Only the low NUM_CH (or DB_WIDTH) bits of write data are ever stored.
  assign wdata_ch     = reg_wdata_i[NUM_CH-1:0];
  assign unused_wdata = ^reg_wdata_i;

  // A threshold of 0 is treated as 1, so both flip on the first mismatch cycle.
  assign thr_m1 = (db_thr_q == '0) ? '0 : db_thr_q - DB_WIDTH'(1);

  assign sync         = sync_q[SYNC_STAGES-1];
  assign rise_evt     = flip & sync;
  assign fall_evt     = flip & ~sync;
  assign pend_clr     = (reg_wr_i && reg_addr_i == ADDR_PEND) ? wdata_ch : '0;
  assign pad_c2p_o    = out_q;
  assign pad_c2p_en_o = dir_q;

  // Shift raw pad inputs through the synchroniser chain.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= pad_p2c_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Per channel: count consecutive mismatch cycles and flag a flip once the threshold is reached.
  always_comb begin
    flip = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      db_cnt_d[i] = '0;
      if (sync[i] != db_q[i]) begin
        if (db_cnt_q[i] >= thr_m1) begin
          flip[i] = 1'b1;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_WIDTH'(1);
        end
      end
    end
  end

  // Register the debounce counters and debounced bits.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      db_q <= '0;
      for (int i = 0; i < NUM_CH; i++) db_cnt_q[i] <= '0;
    end else begin
      db_q <= db_q ^ flip;
      for (int i = 0; i < NUM_CH; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  // Register writes. For pending bits, a new edge event overrides a simultaneous write-one-to-clear.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      dir_q     <= '0;
      out_q     <= '0;
      irq_en_q  <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
      db_thr_q  <= DB_WIDTH'(1);
    end else begin
      pend_q <= (pend_q & ~pend_clr) | (rise_evt & rise_en_q) | (fall_evt & fall_en_q);
      if (reg_wr_i) begin
        case (reg_addr_i)
          ADDR_DIR:     dir_q     <= wdata_ch;
          ADDR_OUT:     out_q     <= wdata_ch;
          ADDR_IRQ_EN:  irq_en_q  <= wdata_ch;
          ADDR_RISE_EN: rise_en_q <= wdata_ch;
          ADDR_FALL_EN: fall_en_q <= wdata_ch;
          ADDR_DB_THR:  db_thr_q  <= reg_wdata_i[DB_WIDTH-1:0];
          default:      ;
        endcase
      end
    end
  end

  // The interrupt is registered, so it reflects the previous cycle's pending state.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= |(pend_q & irq_en_q);
    end
  end

  // Combinational read mux, zero-extended to 32 bits.
  always_comb begin
    reg_rdata_o = '0;
    case (reg_addr_i)
      ADDR_DIR:     reg_rdata_o = 32'(dir_q);
      ADDR_OUT:     reg_rdata_o = 32'(out_q);
      ADDR_IN:      reg_rdata_o = 32'(db_q);
      ADDR_IRQ_EN:  reg_rdata_o = 32'(irq_en_q);
      ADDR_RISE_EN: reg_rdata_o = 32'(rise_en_q);
      ADDR_FALL_EN: reg_rdata_o = 32'(fall_en_q);
      ADDR_PEND:    reg_rdata_o = 32'(pend_q);
      ADDR_DB_THR:  reg_rdata_o = 32'(db_thr_q);
      default:      reg_rdata_o = '0;
    endcase
  end

endmodule

// File: tb/tb_gpio_pad_bank.sv
// tb_gpio_pad_bank: testbench for gpio_pad_bank.
// A reference model turns every clock edge into expected output values and
// queues them. A monitor pops those values and compares them with the DUT
// on the falling edge. A second, 4-channel instance covers the narrow-build
// read behaviour.
module tb_gpio_pad_bank;

  localparam int NUM_CH      = 8;
  localparam int SYNC_STAGES = 2;
  localparam int DB_WIDTH    = 8;

  logic              clk_i;
  logic              rst_n_i;
  logic              reg_wr_i;
  logic [2:0]        reg_addr_i;
  logic [31:0]       reg_wdata_i;
  logic [31:0]       reg_rdata_o;
  logic [NUM_CH-1:0] pad_c2p_o;
  logic [NUM_CH-1:0] pad_c2p_en_o;
  logic [NUM_CH-1:0] pad_p2c_i;
  logic              irq_o;

  logic [31:0]       rdata4;
  logic [3:0]        c2p4;
  logic [3:0]        c2p_en4;
  logic              irq4;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic rd_valid = 1'b0;

  typedef struct {
    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] out;
    logic              irq;
  } out_exp_t;

  out_exp_t    exp_out_q[$];
  logic [31:0] exp_rd_q[$];

  // Reference model state
  logic [NUM_CH-1:0]   m_dir, m_out, m_irqen, m_rise, m_fall, m_pend, m_db;
  logic [DB_WIDTH-1:0] m_thr;
  logic                m_irq;
  int                  m_run [NUM_CH];
  logic [NUM_CH-1:0]   pad_hist[$];

  gpio_pad_bank #(.NUM_CH(NUM_CH), .SYNC_STAGES(SYNC_STAGES), .DB_WIDTH(DB_WIDTH)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .reg_wr_i     (reg_wr_i),
    .reg_addr_i   (reg_addr_i),
    .reg_wdata_i  (reg_wdata_i),
    .reg_rdata_o  (reg_rdata_o),
    .pad_c2p_o    (pad_c2p_o),
    .pad_c2p_en_o (pad_c2p_en_o),
    .pad_p2c_i    (pad_p2c_i),
    .irq_o        (irq_o)
  );

  gpio_pad_bank #(.NUM_CH(4), .SYNC_STAGES(SYNC_STAGES), .DB_WIDTH(DB_WIDTH)) dut4 (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .reg_wr_i     (reg_wr_i),
    .reg_addr_i   (reg_addr_i),
    .reg_wdata_i  (reg_wdata_i),
    .reg_rdata_o  (rdata4),
    .pad_c2p_o    (c2p4),
    .pad_c2p_en_o (c2p_en4),
    .pad_p2c_i    (pad_p2c_i[3:0]),
    .irq_o        (irq4)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] addr);
    case (addr)
      3'd0:    return 32'(m_dir);
      3'd1:    return 32'(m_out);
      3'd2:    return 32'(m_db);
      3'd3:    return 32'(m_irqen);
      3'd4:    return 32'(m_rise);
      3'd5:    return 32'(m_fall);
      3'd6:    return 32'(m_pend);
      default: return 32'(m_thr);
    endcase
  endfunction

  // Reference model: the synchronised value is simply the pad sample from SYNC_STAGES edges ago,
  // and a bit flips once it has disagreed for max(threshold,1) consecutive cycles.
  always @(posedge clk_i) begin : ref_model
    logic [NUM_CH-1:0] sync_v, set_v, clr_v;
    logic              irq_nx;
    int                thr_eff;
    if (!rst_n_i) begin
      m_dir = '0; m_out = '0; m_irqen = '0; m_rise = '0; m_fall = '0;
      m_pend = '0; m_db = '0; m_thr = DB_WIDTH'(1); m_irq = 1'b0;
      for (int i = 0; i < NUM_CH; i++) m_run[i] = 0;
      pad_hist.delete();
      for (int s = 0; s < SYNC_STAGES; s++) pad_hist.push_back('0);
    end else begin
      sync_v  = pad_hist[SYNC_STAGES-1];
      thr_eff = (m_thr == 0) ? 1 : int'(m_thr);
      set_v   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (sync_v[i] != m_db[i]) begin
          m_run[i]++;
          if (m_run[i] >= thr_eff) begin
            m_db[i]  = sync_v[i];
            m_run[i] = 0;
            if (sync_v[i] ? m_rise[i] : m_fall[i]) set_v[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      irq_nx = |(m_pend & m_irqen);
      clr_v  = (reg_wr_i && reg_addr_i == 3'd6) ? reg_wdata_i[NUM_CH-1:0] : '0;
      m_pend = (m_pend & ~clr_v) | set_v;
      m_irq  = irq_nx;
      if (reg_wr_i) begin
        case (reg_addr_i)
          3'd0: m_dir   = reg_wdata_i[NUM_CH-1:0];
          3'd1: m_out   = reg_wdata_i[NUM_CH-1:0];
          3'd3: m_irqen = reg_wdata_i[NUM_CH-1:0];
          3'd4: m_rise  = reg_wdata_i[NUM_CH-1:0];
          3'd5: m_fall  = reg_wdata_i[NUM_CH-1:0];
          3'd7: m_thr   = reg_wdata_i[DB_WIDTH-1:0];
          default: ;
        endcase
      end
      pad_hist.push_front(pad_p2c_i);
      void'(pad_hist.pop_back());
    end
    exp_out_q.push_back('{en: m_dir, out: m_out, irq: m_irq});
  end

  // Monitor: compares pad outputs every cycle and read data whenever a read is presented.
  always @(negedge clk_i) begin : monitor
    out_exp_t e;
    if (exp_out_q.size() > 0) begin
      e = exp_out_q.pop_front();
      check_output("outputs", 32'({pad_c2p_en_o, pad_c2p_o, irq_o}), 32'({e.en, e.out, e.irq}));
    end
    if (rd_valid) begin
      if (exp_rd_q.size() == 0) check_output("rd_queue_empty", 32'd1, 32'd0);
      else check_output("rdata", reg_rdata_o, exp_rd_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic reg_write(input logic [2:0] addr, input logic [31:0] data);
    reg_wr_i    = 1'b1;
    reg_addr_i  = addr;
    reg_wdata_i = data;
    tick();
    reg_wr_i    = 1'b0;
  endtask

  task automatic read_check(input logic [2:0] addr);
    reg_addr_i = addr;
    rd_valid   = 1'b1;
    exp_rd_q.push_back(model_read(addr));
    tick();
    rd_valid   = 1'b0;
  endtask

  task automatic peek_check(input string name, input logic [2:0] addr, input logic [31:0] exp);
    reg_addr_i = addr;
    #1;
    check_output(name, reg_rdata_o, exp);
  endtask

  task automatic apply_stimulus(input int iters);
    int r, ch;
    logic [2:0] a;
    logic [31:0] d;
    for (int k = 0; k < iters; k++) begin
      if (k == iters / 2) begin
        rst_n_i = 1'b0;
        tick();
        rst_n_i = 1'b1;
      end
      r = $urandom_range(0, 9);
      if ($urandom_range(0, 3) == 0) begin
        ch = $urandom_range(0, NUM_CH - 1);
        pad_p2c_i[ch] = ~pad_p2c_i[ch];
      end
      if (r < 3) begin
        a = 3'($urandom_range(0, 7));
        d = $urandom;
        if (a == 3'd7) d = 32'($urandom_range(0, 5));
        reg_write(a, d);
      end else if (r < 6) begin
        read_check(3'($urandom_range(0, 7)));
      end else begin
        tick();
      end
    end
  endtask

  initial begin
    rst_n_i     = 1'b0;
    reg_wr_i    = 1'b0;
    reg_addr_i  = '0;
    reg_wdata_i = '0;
    pad_p2c_i   = '0;
    repeat (3) tick();
    rst_n_i = 1'b1;
    tick();

    // Direction and output value registers
    reg_write(3'd0, 32'h0F);
    check_output("dir_to_en", 32'(pad_c2p_en_o), 32'h0F);
    reg_write(3'd1, 32'h05);
    check_output("out_to_pad", 32'(pad_c2p_o), 32'h05);
    peek_check("dir_read", 3'd0, 32'h0000_000F);

    // Debounce latency with threshold 4, then a too-short pulse
    reg_write(3'd7, 32'd4);
    pad_p2c_i = 8'h08;
    repeat (5) tick();
    peek_check("in_before_latency", 3'd2, 32'h00);
    tick();
    peek_check("in_at_latency", 3'd2, 32'h08);
    pad_p2c_i = 8'h00;
    repeat (8) tick();
    pad_p2c_i = 8'h08;
    repeat (3) tick();
    pad_p2c_i = 8'h00;
    repeat (10) tick();
    peek_check("in_short_pulse", 3'd2, 32'h00);

    // Rising edge sets pending, interrupt follows one cycle later, W1C clears
    reg_write(3'd7, 32'd1);
    reg_write(3'd4, 32'h01);
    reg_write(3'd3, 32'h01);
    pad_p2c_i = 8'h01;
    repeat (3) tick();
    peek_check("pend_set", 3'd6, 32'h01);
    check_output("irq_lag", 32'(irq_o), 32'd0);
    tick();
    check_output("irq_set", 32'(irq_o), 32'd1);
    reg_write(3'd6, 32'h01);
    peek_check("pend_w1c", 3'd6, 32'h00);
    tick();
    check_output("irq_clear", 32'(irq_o), 32'd0);

    // Set and clear of a pending bit in the same cycle: set wins
    reg_write(3'd5, 32'h02);
    pad_p2c_i = 8'h03;
    repeat (6) tick();
    pad_p2c_i = 8'h01;
    tick();
    tick();
    reg_write(3'd6, 32'h02);
    peek_check("pend_set_wins", 3'd6, 32'h02);
    reg_write(3'd6, 32'h02);
    peek_check("pend_cleared", 3'd6, 32'h00);

    // Randomised traffic against the reference model
    apply_stimulus(400);

    // Reset with everything set; pads held high across release
    reg_write(3'd0, 32'hFF);
    reg_write(3'd4, 32'hFF);
    reg_write(3'd3, 32'hFF);
    pad_p2c_i = 8'hFF;
    rst_n_i = 1'b0;
    tick();
    rst_n_i = 1'b1;
    check_output("rst_en", 32'(pad_c2p_en_o), 32'd0);
    check_output("rst_out", 32'(pad_c2p_o), 32'd0);
    check_output("rst_irq", 32'(irq_o), 32'd0);
    peek_check("rst_thr", 3'd7, 32'd1);
    peek_check("rst_pend", 3'd6, 32'd0);
    tick();
    check_output("rst_en_after", 32'(pad_c2p_en_o), 32'd0);
    repeat (2) tick();
    peek_check("in_after_release", 3'd2, 32'hFF);
    peek_check("no_pend_after_release", 3'd6, 32'd0);
    read_check(3'd2);
    read_check(3'd6);

    // Upper data bits are ignored and read back as zero on both builds
    reg_write(3'd0, 32'hFFFF_FFFF);
    check_output("en_all", 32'(pad_c2p_en_o), 32'hFF);
    check_output("en4_all", 32'(c2p_en4), 32'h0F);
    peek_check("dir_read8", 3'd0, 32'h0000_00FF);
    check_output("dir_read4", rdata4, 32'h0000_000F);

    repeat (2) tick();
    $display("[TB] %0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
